// File: rtl/map_write_arbiter.sv
// Round-robin arbiter sharing the single map_mem write port between NUM_REQ writers,
// with optional locked bursts that keep one writer's multi-tile sequence atomic.
module map_write_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 2,
  parameter int BURST_MAX  = 16,
  localparam int OW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CW = $clog2(BURST_MAX + 1)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_REQ-1:0]                   wr_req,
  input  logic [NUM_REQ-1:0]                   wr_lock,
  input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]   wr_addr_req,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   wr_data_req,
  output logic [NUM_REQ-1:0]                   wr_granted,
  output logic                                 we,
  output logic [ADDR_WIDTH-1:0]                wr_addr,
  output logic [DATA_WIDTH-1:0]                wr_data,
  output logic [OW-1:0]                        owner,
  output logic                                 locked
);

  typedef enum logic [0:0] {
    ST_ARB    = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  state_t                 state_r, state_s;
  logic [OW-1:0]          ptr_r, ptr_s;
  logic [OW-1:0]          owner_r, owner_s;
  logic [CW-1:0]          burst_r, burst_s;
  logic [NUM_REQ-1:0]     wr_granted_r, wr_granted_s;
  logic                   we_r;
  logic [ADDR_WIDTH-1:0]  wr_addr_r, wr_addr_s;
  logic [DATA_WIDTH-1:0]  wr_data_r, wr_data_s;
  logic [NUM_REQ-1:0]     eligible_s;
  logic                   found_s;
  logic [OW-1:0]          win_s;
  logic                   grant_s;
  logic [OW-1:0]          gidx_s;

  function automatic logic [OW-1:0] next_idx(input logic [OW-1:0] i);
    if (i == OW'(NUM_REQ - 1)) begin
      next_idx = '0;
    end else begin
      next_idx = i + OW'(1);
    end
  endfunction

  function automatic logic [OW-1:0] rr_idx(input logic [OW-1:0] base, input int k);
    rr_idx = OW'((int'(base) + k) % NUM_REQ);
  endfunction

  // A writer granted last cycle still shows its old request, so mask it out.
  assign eligible_s = wr_req & ~wr_granted_r;

  // Round-robin search for the first eligible writer starting at ptr.
  always_comb begin
    found_s = 1'b0;
    win_s   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found_s && eligible_s[rr_idx(ptr_r, k)]) begin
        found_s = 1'b1;
        win_s   = rr_idx(ptr_r, k);
      end else begin
        found_s = found_s;
      end
    end
  end

  // Next-state, pointer, burst count and grant decision.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    owner_s = owner_r;
    burst_s = burst_r;
    grant_s = 1'b0;
    gidx_s  = owner_r;
    case (state_r)
      ST_ARB: begin
        if (found_s) begin
          grant_s = 1'b1;
          gidx_s  = win_s;
          ptr_s   = next_idx(win_s);
          owner_s = win_s;
          if (wr_lock[win_s] && (BURST_MAX > 1)) begin
            state_s = ST_LOCKED;
            burst_s = CW'(1);
          end else begin
            burst_s = '0;
          end
        end else begin
          burst_s = '0;
        end
      end
      ST_LOCKED: begin
        // Release when the owner drops its lock, or abandons the request between grants.
        if (!wr_lock[owner_r] || (!wr_req[owner_r] && !wr_granted_r[owner_r])) begin
          state_s = ST_ARB;
          burst_s = '0;
        end else if (eligible_s[owner_r]) begin
          grant_s = 1'b1;
          gidx_s  = owner_r;
          ptr_s   = next_idx(owner_r);
          if ((burst_r + CW'(1)) >= CW'(BURST_MAX)) begin
            state_s = ST_ARB;
            burst_s = '0;
          end else begin
            burst_s = burst_r + CW'(1);
          end
        end else begin
          state_s = ST_LOCKED;
        end
      end
      default: begin
        state_s = ST_ARB;
        burst_s = '0;
      end
    endcase
  end

  // Write-port payload for the winner; zero when idle.
  always_comb begin
    wr_granted_s = '0;
    wr_addr_s    = '0;
    wr_data_s    = '0;
    if (grant_s) begin
      wr_granted_s = NUM_REQ'(1) << gidx_s;
      wr_addr_s    = wr_addr_req[gidx_s];
      wr_data_s    = wr_data_req[gidx_s];
    end else begin
      wr_granted_s = '0;
    end
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_ARB;
      ptr_r        <= '0;
      owner_r      <= '0;
      burst_r      <= '0;
      wr_granted_r <= '0;
      we_r         <= 1'b0;
      wr_addr_r    <= '0;
      wr_data_r    <= '0;
    end else begin
      state_r      <= state_s;
      ptr_r        <= ptr_s;
      owner_r      <= owner_s;
      burst_r      <= burst_s;
      wr_granted_r <= wr_granted_s;
      we_r         <= grant_s;
      wr_addr_r    <= wr_addr_s;
      wr_data_r    <= wr_data_s;
    end
  end

  assign wr_granted = wr_granted_r;
  assign we         = we_r;
  assign wr_addr    = wr_addr_r;
  assign wr_data    = wr_data_r;
  assign owner      = owner_r;
  assign locked     = (state_r == ST_LOCKED);

endmodule
